// File: rtl/connect4_pkg.sv
// Shared types and constants for the Connect Four drop controller.
//   COLS/ROWS/CELLS  - board geometry (cell index = row*7 + col, row 0 at top)
//   state_t          - drop controller states
//   WIN_*            - winner encodings
//   cell_idx()       - row/col to board bit index
package connect4_pkg;

    localparam int COLS  = 7;
    localparam int ROWS  = 6;
    localparam int CELLS = COLS * ROWS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FALL,
        S_PLACE,
        S_CHECK,
        S_WAIT,
        S_OVER
    } state_t;

    localparam logic [1:0] WIN_NONE   = 2'b00;
    localparam logic [1:0] WIN_RED    = 2'b01;
    localparam logic [1:0] WIN_YELLOW = 2'b10;
    localparam logic [1:0] WIN_DRAW   = 2'b11;

    function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return ({3'b000, row} * 6'd7) + {3'b000, col};
    endfunction

endpackage

// File: rtl/chip_drop_ctrl_if.sv
// Bus between the drop controller, the player-input logic and the win checker.
//   slave  - the drop controller side (chip_drop_ctrl)
//   master - the surrounding logic (player input + win checker)
// Carries the move request/reject handshake, board vectors, checker
// enables/results, animation position and game status.
interface chip_drop_ctrl_if;
    import connect4_pkg::*;

    logic             new_game;
    logic             move_valid;
    logic [2:0]       move_col;
    logic             move_ready;
    logic             move_reject;
    logic [CELLS-1:0] red;
    logic [CELLS-1:0] yellow;
    logic             check_red;
    logic             check_yellow;
    logic             board_clr_n;
    logic             win_in;
    logic             red_win_in;
    logic             yellow_win_in;
    logic             turn;
    logic             falling;
    logic [2:0]       fall_row;
    logic [2:0]       fall_col;
    logic             game_over;
    logic [1:0]       winner;

    modport slave (
        input  new_game, move_valid, move_col, win_in, red_win_in, yellow_win_in,
        output move_ready, move_reject, red, yellow, check_red, check_yellow,
               board_clr_n, turn, falling, fall_row, fall_col, game_over, winner
    );

    modport master (
        output new_game, move_valid, move_col, win_in, red_win_in, yellow_win_in,
        input  move_ready, move_reject, red, yellow, check_red, check_yellow,
               board_clr_n, turn, falling, fall_row, fall_col, game_over, winner
    );

endinterface

// File: rtl/drop_row_finder.sv
// Combinational landing-row search for one column.
//   occupancy  in  - red | yellow board
//   col        in  - column to search (0..6)
//   target_row out - lowest empty row (largest row index) in the column
//   col_full   out - top cell of the column is occupied
module drop_row_finder
    import connect4_pkg::*;
(
    input  logic [CELLS-1:0] occupancy,
    input  logic [2:0]       col,
    output logic [2:0]       target_row,
    output logic             col_full
);

    logic [5:0] idx;

    always_comb begin
        target_row = 3'd0;
        idx        = 6'd0;
        // Later (lower) rows overwrite earlier ones, leaving the bottom-most hole.
        for (int r = 0; r < ROWS; r++) begin
            idx = cell_idx(3'(r), col);
            if (col < 3'(COLS) && !occupancy[idx]) begin
                target_row = 3'(r);
            end
        end
    end

    assign col_full = (col < 3'(COLS)) ? occupancy[cell_idx(3'd0, col)] : 1'b1;

endmodule

// File: rtl/chip_drop_ctrl.sv
// Board-state writer and turn sequencer for Connect Four.
//   clk, resetn - clock, synchronous active-low reset
//   bus         - chip_drop_ctrl_if.slave: move handshake, board vectors,
//                 win checker enables/results, animation and game status
// Optional build macro FALL_ANIM_EN enables the per-row fall animation
// (FALL_TICKS cycles per row); without it a move goes straight to PLACE.
//
// state | meaning
// IDLE  | waiting for a move, move_ready high
// FALL  | chip animating down the column
// PLACE | commit chip into the board vector
// CHECK | one-cycle enable to the win checker
// WAIT  | checker flags settle, decide win/draw/next turn
// OVER  | game finished, only new_game/reset leave
module chip_drop_ctrl
    import connect4_pkg::*;
#(
    parameter int FALL_TICKS = 4
) (
    input logic            clk,
    input logic            resetn,
    chip_drop_ctrl_if.slave bus
);

    if (FALL_TICKS < 1) begin : g_bad_fall_ticks
        $error("FALL_TICKS must be at least 1");
    end

    state_t           state_q, state_d;
    logic [CELLS-1:0] red_q, red_d, yellow_q, yellow_d;
    logic             turn_q, turn_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [2:0]       col_q, col_d, row_q, row_d;
    logic             over_q, over_d;
    logic [1:0]       winner_q, winner_d;
    logic             reject_q, reject_d;
    logic             clr_n_q, clr_n_d;

    logic [2:0]       target_row;
    logic             col_full;
    logic [5:0]       place_idx;

`ifdef FALL_ANIM_EN
    localparam int TICK_W = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(FALL_TICKS - 1);
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        fall_row_q, fall_row_d;
`endif

    drop_row_finder u_finder (
        .occupancy (red_q | yellow_q),
        .col       (bus.move_col),
        .target_row(target_row),
        .col_full  (col_full)
    );

    assign place_idx = cell_idx(row_q, col_q);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            red_q      <= '0;
            yellow_q   <= '0;
            turn_q     <= 1'b0;
            cnt_q      <= 6'd0;
            col_q      <= 3'd0;
            row_q      <= 3'd0;
            over_q     <= 1'b0;
            winner_q   <= WIN_NONE;
            reject_q   <= 1'b0;
            clr_n_q    <= 1'b1;
`ifdef FALL_ANIM_EN
            tick_q     <= '0;
            fall_row_q <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            red_q      <= red_d;
            yellow_q   <= yellow_d;
            turn_q     <= turn_d;
            cnt_q      <= cnt_d;
            col_q      <= col_d;
            row_q      <= row_d;
            over_q     <= over_d;
            winner_q   <= winner_d;
            reject_q   <= reject_d;
            clr_n_q    <= clr_n_d;
`ifdef FALL_ANIM_EN
            tick_q     <= tick_d;
            fall_row_q <= fall_row_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        red_d      = red_q;
        yellow_d   = yellow_q;
        turn_d     = turn_q;
        cnt_d      = cnt_q;
        col_d      = col_q;
        row_d      = row_q;
        over_d     = over_q;
        winner_d   = winner_q;
        reject_d   = 1'b0;
        clr_n_d    = 1'b1;
`ifdef FALL_ANIM_EN
        tick_d     = tick_q;
        fall_row_d = fall_row_q;
`endif
        if (bus.new_game) begin
            // Drops any chip in flight; nothing latched for it is ever committed.
            state_d  = S_IDLE;
            red_d    = '0;
            yellow_d = '0;
            turn_d   = 1'b0;
            cnt_d    = 6'd0;
            col_d    = 3'd0;
            row_d    = 3'd0;
            over_d   = 1'b0;
            winner_d = WIN_NONE;
            clr_n_d  = 1'b0;
`ifdef FALL_ANIM_EN
            tick_d     = '0;
            fall_row_d = 3'd0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.move_valid) begin
                        if (bus.move_col >= 3'(COLS) || col_full) begin
                            reject_d = 1'b1;
                        end else begin
                            col_d = bus.move_col;
                            row_d = target_row;
`ifdef FALL_ANIM_EN
                            state_d    = S_FALL;
                            tick_d     = TICK_MAX;
                            fall_row_d = 3'd0;
`else
                            state_d = S_PLACE;
`endif
                        end
                    end
                end
`ifdef FALL_ANIM_EN
                S_FALL: begin
                    if (tick_q == '0) begin
                        tick_d = TICK_MAX;
                        if (fall_row_q == row_q) begin
                            state_d    = S_PLACE;
                            fall_row_d = 3'd0;
                        end else begin
                            fall_row_d = fall_row_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q - 1'b1;
                    end
                end
`endif
                S_PLACE: begin
                    if (turn_q) yellow_d[place_idx] = 1'b1;
                    else        red_d[place_idx]    = 1'b1;
                    cnt_d   = cnt_q + 6'd1;
                    state_d = S_CHECK;
                end
                S_CHECK: state_d = S_WAIT;
                S_WAIT: begin
                    if (bus.win_in) begin
                        over_d  = 1'b1;
                        state_d = S_OVER;
                        // Ambiguous checker flags fall back to the colour that just moved.
                        if (bus.red_win_in ^ bus.yellow_win_in)
                            winner_d = {bus.yellow_win_in, bus.red_win_in};
                        else
                            winner_d = turn_q ? WIN_YELLOW : WIN_RED;
                    end else if (cnt_q == 6'(CELLS)) begin
                        over_d   = 1'b1;
                        winner_d = WIN_DRAW;
                        state_d  = S_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = S_IDLE;
                    end
                end
                S_OVER:  state_d = S_OVER;
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.move_ready   = (state_q == S_IDLE);
    assign bus.move_reject  = reject_q;
    assign bus.red          = red_q;
    assign bus.yellow       = yellow_q;
    assign bus.check_red    = (state_q == S_CHECK) && !turn_q;
    assign bus.check_yellow = (state_q == S_CHECK) &&  turn_q;
    assign bus.board_clr_n  = clr_n_q;
    assign bus.turn         = turn_q;
    assign bus.game_over    = over_q;
    assign bus.winner       = winner_q;
`ifdef FALL_ANIM_EN
    assign bus.falling      = (state_q == S_FALL);
    assign bus.fall_row     = fall_row_q;
    assign bus.fall_col     = (state_q == S_FALL) ? col_q : 3'd0;
`else
    assign bus.falling      = 1'b0;
    assign bus.fall_row     = 3'd0;
    assign bus.fall_col     = 3'd0;
`endif

endmodule
